// File: rtl/calc_sequencer.sv
// calc_sequencer
// ---------------------------------------------------------------------------
// Front-end control stage for the eight-bit signed calculator. A single raw
// ENTER pushbutton walks the user through: load A -> load B -> pick the
// operation and compute -> show the result -> back to A. Before LoadR fires,
// the block waits SETTLE_CYCLES so the ripple adder output is stable.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable CLK cycles needed to accept a new
//                    button level (500000 = 10 ms at 50 MHz)
//   SETTLE_CYCLES    CLK cycles from the ADDSUB capture to the LoadR pulse
//                    (legal range 1..255)
//
// Ports
//   CLK        system clock, rising edge
//   CLR        asynchronous active-low reset
//   KEY_ENTER  raw pushbutton, active-low, asynchronous to CLK
//   SW_OP      operation select (0 = add, 1 = subtract)
//   LoadA      one-cycle pulse, load register A
//   LoadB      one-cycle pulse, load register B
//   LoadR      one-cycle pulse, load the result register
//   ADDSUB     registered operation select held for the ALU
//   ClrRegs    one-cycle clear for the ALU registers (optional feature)
//   Step       current state code
//   Busy       high while computing
//
// Build option
//   CALC_SEQ_CLEAR_PULSE_EN  when defined, leaving SHOW_R pulses ClrRegs for
//                            one cycle; when undefined ClrRegs is constant 0.
// ---------------------------------------------------------------------------
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       KEY_ENTER,
  input  logic       SW_OP,
  output logic       LoadA,
  output logic       LoadB,
  output logic       LoadR,
  output logic       ADDSUB,
  output logic       ClrRegs,
  output logic [2:0] Step,
  output logic       Busy
);

  // The debounce counter only has to count up to DEBOUNCE_CYCLES-1; the
  // flip happens on the read that would have taken it to DEBOUNCE_CYCLES.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SHOW_R  = 3'd4
  } state_t;

  logic            sync_meta;
  logic            sync_key;
  logic            accepted_level;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic [7:0]      settle_cnt;
  state_t          state;

  // Two-flop synchronizer for the asynchronous button. Both flops reset to
  // the released level so leaving reset never looks like an edge.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync_meta <= 1'b1;
      sync_key  <= 1'b1;
    end else begin
      sync_meta <= KEY_ENTER;
      sync_key  <= sync_meta;
    end
  end

  // Debouncer: the accepted level only changes after the synchronized level
  // has disagreed with it for DEBOUNCE_CYCLES reads in a row. A single
  // agreeing read throws away the partial count. Only the 1->0 flip raises
  // the press strobe, so holding or releasing the button never adds events.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      accepted_level <= 1'b1;
      db_cnt         <= '0;
      press          <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_key == accepted_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        accepted_level <= sync_key;
        db_cnt         <= '0;
        press          <= ~sync_key;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

`ifdef CALC_SEQ_CLEAR_PULSE_EN
  logic clr_regs_q;
  assign ClrRegs = clr_regs_q;
`else
  assign ClrRegs = 1'b0;
`endif

  // Sequencer FSM. Every output is a register; pulses default low each cycle
  // so they are exactly one cycle wide. Busy is held through the LoadR cycle
  // and drops on the following edge once the FSM sits in SHOW_R. A press
  // strobe that arrives in CALC is simply not looked at, so it is lost.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= WAIT_A;
      LoadA      <= 1'b0;
      LoadB      <= 1'b0;
      LoadR      <= 1'b0;
      ADDSUB     <= 1'b0;
      Busy       <= 1'b0;
      settle_cnt <= '0;
`ifdef CALC_SEQ_CLEAR_PULSE_EN
      clr_regs_q <= 1'b0;
`endif
    end else begin
      LoadA <= 1'b0;
      LoadB <= 1'b0;
      LoadR <= 1'b0;
      Busy  <= 1'b0;
`ifdef CALC_SEQ_CLEAR_PULSE_EN
      clr_regs_q <= 1'b0;
`endif
      case (state)
        WAIT_A: begin
          if (press) begin
            LoadA <= 1'b1;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (press) begin
            LoadB <= 1'b1;
            state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (press) begin
            ADDSUB     <= SW_OP;
            settle_cnt <= '0;
            Busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          Busy <= 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            LoadR <= 1'b1;
            state <= SHOW_R;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SHOW_R: begin
          if (press) begin
            state <= WAIT_A;
`ifdef CALC_SEQ_CLEAR_PULSE_EN
            clr_regs_q <= 1'b1;
`endif
          end
        end
        default: begin
          state <= WAIT_A;
        end
      endcase
    end
  end

  assign Step = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
// ---------------------------------------------------------------------------
// Scoreboard bench for calc_sequencer with DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3.
// Stimulus pushes the expected pulse (kind, cycle, Step, ADDSUB, Busy) into
// a queue; a monitor on the falling edge pops one entry for every pulse the
// DUT shows. Direct state checks cover reset values and Busy/ADDSUB timing.
// Define CALC_SEQ_CLEAR_PULSE_EN to also expect the ClrRegs pulses.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       KEY_ENTER;
  logic       SW_OP;
  logic       LoadA;
  logic       LoadB;
  logic       LoadR;
  logic       ADDSUB;
  logic       ClrRegs;
  logic [2:0] Step;
  logic       Busy;

  localparam int K_A   = 0;
  localparam int K_B   = 1;
  localparam int K_R   = 2;
  localparam int K_CLR = 3;

  typedef struct {
    int kind;
    int at;
    int step;
    int addsub;
    int busy;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;

  calc_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (3)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .KEY_ENTER(KEY_ENTER),
    .SW_OP    (SW_OP),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .LoadR    (LoadR),
    .ADDSUB   (ADDSUB),
    .ClrRegs  (ClrRegs),
    .Step     (Step),
    .Busy     (Busy)
  );

  // 10 ns clock; cyc names the cycle that begins at each rising edge.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // One comparison: counts it and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic expectPulse(input int kind, input int at, input int step,
                             input int addsub, input int busy);
    exp_t e;
    e.kind = kind; e.at = at; e.step = step; e.addsub = addsub; e.busy = busy;
    sb.push_back(e);
  endtask

  // Holds the button low for 'hold' cycles, then released for 'gap' cycles.
  task automatic applyStimulus(input int hold, input int gap);
    KEY_ENTER = 1'b0;
    repeat (hold) @(negedge CLK);
    KEY_ENTER = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  // Advances to the falling edge inside cycle n (bounded).
  task automatic waitCycle(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge CLK);
      guard++;
    end
  endtask

  // Clean press whose pulse is predicted at the standard 7-cycle latency.
  task automatic pressExpect(input int kind, input int step, input int addsub);
    int c0 = cyc;
    expectPulse(kind, c0 + 7, step, addsub, 0);
    applyStimulus(10, 10);
  endtask

  // Press from SHOW_R back to WAIT_A; ClrRegs only in the clear-pulse build.
  task automatic returnPress(input int addsub);
    int c0 = cyc;
`ifdef CALC_SEQ_CLEAR_PULSE_EN
    expectPulse(K_CLR, c0 + 7, 0, addsub, 0);
`endif
    KEY_ENTER = 1'b0;
    waitCycle(c0 + 6);
    checkOutput("show_r_step_before_press", Step, 4);
    waitCycle(c0 + 7);
    checkOutput("return_step", Step, 0);
    checkOutput("return_addsub", ADDSUB, addsub);
    waitCycle(c0 + 10);
    KEY_ENTER = 1'b1;
    waitCycle(c0 + 20);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_loada"},   LoadA,   0);
    checkOutput({tag, "_loadb"},   LoadB,   0);
    checkOutput({tag, "_loadr"},   LoadR,   0);
    checkOutput({tag, "_addsub"},  ADDSUB,  0);
    checkOutput({tag, "_clrregs"}, ClrRegs, 0);
    checkOutput({tag, "_step"},    Step,    0);
    checkOutput({tag, "_busy"},    Busy,    0);
  endtask

  // Monitor: every pulse must match the next scoreboard entry exactly.
  always @(negedge CLK) begin : monitor
    int   n;
    int   kind;
    exp_t e;
    if (CLR === 1'b1) begin
      n = int'(LoadA) + int'(LoadB) + int'(LoadR) + int'(ClrRegs);
      if (n > 1) begin
        checkOutput("pulses_exclusive", n, 1);
      end else if (n == 1) begin
        kind = LoadA ? K_A : (LoadB ? K_B : (LoadR ? K_R : K_CLR));
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse_kind", kind, -1);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind",   kind,   e.kind);
          checkOutput("pulse_cycle",  cyc,    e.at);
          checkOutput("pulse_step",   Step,   e.step);
          checkOutput("pulse_addsub", ADDSUB, e.addsub);
          checkOutput("pulse_busy",   Busy,   e.busy);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int c0;
    int e_cyc;
    int r;

    CLR       = 1'b0;
    KEY_ENTER = 1'b1;
    SW_OP     = 1'b0;

    // Reset values while CLR is held low.
    @(negedge CLK);
    checkAllZero("reset");
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("idle_step", Step, 0);

    // Clean press held for 50 cycles: exactly one LoadA in cycle 7.
    c0 = cyc;
    expectPulse(K_A, c0 + 7, 1, 0, 0);
    KEY_ENTER = 1'b0;
    waitCycle(c0 + 6);
    checkOutput("step_before_loada", Step, 0);
    waitCycle(c0 + 7);
    checkOutput("step_at_loada", Step, 1);
    waitCycle(c0 + 50);
    checkOutput("step_after_hold", Step, 1);
    KEY_ENTER = 1'b1;
    waitCycle(c0 + 60);

    // Mid-run reset: outputs clear asynchronously.
    CLR = 1'b0;
    #1;
    checkAllZero("midrun_reset");
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    repeat (10) @(negedge CLK);
    checkOutput("after_reset_step", Step, 0);

    // Bounce: ten 3-low/1-high glitches give nothing; then a 4-cycle low.
    for (int i = 0; i < 10; i++) begin
      KEY_ENTER = 1'b0;
      repeat (3) @(negedge CLK);
      KEY_ENTER = 1'b1;
      @(negedge CLK);
    end
    checkOutput("bounce_step", Step, 0);
    c0 = cyc;
    expectPulse(K_A, c0 + 7, 1, 0, 0);
    applyStimulus(4, 16);
    checkOutput("bounce_then_press_step", Step, 1);

    // Full sequence with subtract.
    pressExpect(K_B, 2, 0);
    SW_OP = 1'b1;
    c0    = cyc;
    e_cyc = c0 + 6;
    expectPulse(K_R, e_cyc + 4, 4, 1, 1);
    KEY_ENTER = 1'b0;
    waitCycle(e_cyc);
    checkOutput("busy_at_event", Busy, 0);
    checkOutput("addsub_at_event", ADDSUB, 0);
    waitCycle(e_cyc + 1);
    checkOutput("busy_rise", Busy, 1);
    checkOutput("addsub_capture", ADDSUB, 1);
    checkOutput("calc_step", Step, 3);
    waitCycle(e_cyc + 3);
    checkOutput("calc_step_late", Step, 3);
    waitCycle(c0 + 10);
    KEY_ENTER = 1'b1;
    waitCycle(e_cyc + 5);
    checkOutput("busy_fall", Busy, 0);
    checkOutput("show_step", Step, 4);
    waitCycle(c0 + 20);
    returnPress(1);

    // Button activity and SW_OP toggle during CALC are ignored.
    pressExpect(K_A, 1, 1);
    pressExpect(K_B, 2, 1);
    SW_OP = 1'b0;
    c0    = cyc;
    e_cyc = c0 + 6;
    expectPulse(K_R, e_cyc + 4, 4, 0, 1);
    KEY_ENTER = 1'b0;
    waitCycle(c0 + 4);
    KEY_ENTER = 1'b1;
    waitCycle(e_cyc + 1);
    checkOutput("add_capture", ADDSUB, 0);
    SW_OP     = 1'b1;
    KEY_ENTER = 1'b0;
    waitCycle(e_cyc + 3);
    KEY_ENTER = 1'b1;
    waitCycle(e_cyc + 5);
    checkOutput("addsub_held", ADDSUB, 0);
    checkOutput("calc_press_step", Step, 4);
    waitCycle(e_cyc + 20);
    checkOutput("calc_press_step_late", Step, 4);
    SW_OP = 1'b0;
    returnPress(0);

    // Reset two cycles into CALC aborts the computation.
    pressExpect(K_A, 1, 0);
    pressExpect(K_B, 2, 0);
    SW_OP = 1'b1;
    c0    = cyc;
    e_cyc = c0 + 6;
    KEY_ENTER = 1'b0;
    waitCycle(c0 + 4);
    KEY_ENTER = 1'b1;
    waitCycle(e_cyc + 1);
    checkOutput("abort_addsub_before", ADDSUB, 1);
    waitCycle(e_cyc + 2);
    CLR = 1'b0;
    #1;
    checkAllZero("calc_reset");
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    repeat (15) @(negedge CLK);
    checkOutput("abort_step", Step, 0);
    checkOutput("abort_addsub", ADDSUB, 0);
    checkOutput("abort_busy", Busy, 0);

    // Button held through reset gives one LoadA once debounced.
    SW_OP     = 1'b0;
    KEY_ENTER = 1'b0;
    CLR       = 1'b0;
    repeat (3) @(negedge CLK);
    r   = cyc;
    CLR = 1'b1;
    expectPulse(K_A, r + 7, 1, 0, 0);
    waitCycle(r + 12);
    KEY_ENTER = 1'b1;
    waitCycle(r + 25);
    checkOutput("held_reset_step", Step, 1);

    repeat (5) @(negedge CLK);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Front-end control stage for the eight-bit signed calculator. It turns one raw ENTER pushbutton and one operation switch into the ALU datapath controls: LoadA, LoadB, ADDSUB, LoadR and an optional register clear. It steps the user through the sequence load A → load B → choose operation and compute → show result → back to A, and it waits a configurable settle time so the ripple adder output is stable before LoadR fires. It sits directly upstream of the two-function ALU, whose register clocks and Reset it drives.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable CLK cycles required to accept a new button level (10 ms at 50 MHz).
- SETTLE_CYCLES, 4, CLK cycles between ADDSUB capture and the LoadR pulse; legal range is 1 to 255.
- CLK  in  1  single system clock; all logic is rising-edge.
- CLR  in  1  asynchronous, active-low reset.
- KEY_ENTER  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLK.
- SW_OP  in  1  operation select: 0 = add, 1 = subtract.
- LoadA  out  1  one-cycle pulse that loads register A.
- LoadB  out  1  one-cycle pulse that loads register B.
- LoadR  out  1  one-cycle pulse that loads the result register.
- ADDSUB  out  1  registered operation select held for the ALU.
- ClrRegs  out  1  one-cycle active-high clear for the ALU registers (see Configuration).
- Step  out  3  current state code.
- Busy  out  1  high while in CALC.

## Operation
- Input path: KEY_ENTER passes through a 2-flop synchronizer, then the debouncer.
  - The debouncer holds an accepted level, which is 1 (released) after reset.
  - When the synchronized level differs from the accepted level, a counter increments each cycle. Any cycle where it equals the accepted level resets the counter to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level flips and the counter clears.
  - A press event is a single-cycle strobe raised when the accepted level goes 1→0. A release raises no event. Holding the button never repeats.
- FSM states and Step codes: WAIT_A=0, WAIT_B=1, WAIT_OP=2, CALC=3, SHOW_R=4. Codes 5–7 are unreachable; if entered, the FSM goes to WAIT_A on the next cycle.
- WAIT_A + press: LoadA pulses, go to WAIT_B.
- WAIT_B + press: LoadB pulses, go to WAIT_OP.
- WAIT_OP + press: ADDSUB ← SW_OP, settle counter cleared, go to CALC.
- CALC: the settle counter increments each cycle. When it reaches SETTLE_CYCLES, LoadR pulses and the FSM goes to SHOW_R. Press events in CALC are discarded, not queued.
- SHOW_R + press: go to WAIT_A. ClrRegs behaviour on this transition is set by Configuration.
- ADDSUB changes only on the WAIT_OP→CALC transition. SW_OP is ignored at all other times.
- At most one of LoadA, LoadB, LoadR, ClrRegs is high in any cycle.
- All outputs are registered; no output is combinational from an input.

## Timing
- Reset (CLR=0): immediately and asynchronously, all outputs are 0, Step=0, the accepted level is 1, and all counters are 0.
- Reset during CALC aborts the computation; no LoadR is issued after CLR returns high.
- First active edge after CLR deasserts: the FSM responds only to new press events. A button already held through reset produces one event once it is debounced.
- Press latency: KEY_ENTER falls and stays low from cycle 0.
  - The synchronized level is low at cycle 2.
  - The press event is raised at cycle 2+DEBOUNCE_CYCLES.
  - The Load pulse (or ADDSUB update) is high in cycle 3+DEBOUNCE_CYCLES.
- Compute latency: ADDSUB is updated and Busy rises in the same cycle E+1, where E is the event cycle. LoadR is high in cycle E+1+SETTLE_CYCLES. Busy falls in the cycle after LoadR.
- Bounce: any low glitch shorter than DEBOUNCE_CYCLES consecutive cycles produces no event.
- Pulses are exactly one CLK cycle wide. The ALU registers capture on the rising edge of each pulse.

## Configuration
- CALC_SEQ_CLEAR_PULSE_EN defined: the SHOW_R→WAIT_A transition drives ClrRegs high for exactly one cycle, in the same cycle Step becomes 0. This wipes A, B and R for the next calculation.
- CALC_SEQ_CLEAR_PULSE_EN undefined: ClrRegs is constant 0. The SHOW_R→WAIT_A transition issues no pulse, and the ALU registers keep their values until overwritten.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3.
- Reset: CLR low mid-run, then high → all outputs 0 and Step=0 while CLR is low; no pulses afterwards until a press.
- Clean press: KEY_ENTER low from cycle 0 → LoadA high only in cycle 7, Step=1 from cycle 7; holding the button 50 cycles produces no further pulse.
- Bounce rejection: KEY_ENTER low for 3 cycles, high for 1, repeated 10 times → no event, Step unchanged; a following stable 4-cycle low → exactly one LoadA.
- Full sequence with SW_OP=1: four clean presses → LoadA, then LoadB, then ADDSUB=1 with Busy high at E+1, then LoadR at E+4, Step=4; the fourth press gives Step=0. ClrRegs pulses on the fourth press only with CALC_SEQ_CLEAR_PULSE_EN.
- Press during CALC plus a SW_OP toggle during CALC → ignored: LoadR still at E+4, ADDSUB unchanged, Step=4 (not 0).
- Reset in CALC: CLR pulsed low at E+2 → no LoadR, and Step=0 and ADDSUB=0 after release.
